// File: rtl/x_fifo_arb_pkg.sv
// Shared types for the FIFO write arbiter: arbitration state and source-ID width helper.
package x_fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/x_rr_pick.sv
// Rotate-priority picker: first set bit of req searching upward from ptr, wrapping N-1 -> 0.
// Purely combinational; ptr must be < N.
module x_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/x_fifo_wr_arb.sv
// N-to-1 round-robin arbiter feeding a FIFO write port through one output register; 1-cycle accept-to-write.
// Define XFIFO_ARB_PKT_LOCK_EN to hold the grant for a whole packet (until req_last); otherwise re-arbitrate per beat.
module x_fifo_wr_arb
  import x_fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 8,
  localparam int IW = id_width(N),
  localparam int OW = DW + IW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            fifo_we,
  input  logic            fifo_full_n,
  output logic [OW-1:0]   fifo_din,
  output logic [IW-1:0]   grant_id
);

  logic          o_vld;
  logic [OW-1:0] o_data;
  logic          accept;
  logic          fire;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  gnt_oh;
  logic [IW-1:0] gnt_idx;
  logic [DW-1:0] sel_data;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_ptr_d;

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] i);
    if (i == IW'(N - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Stage takes a beat when empty or draining this cycle; nothing is accepted while in reset.
  assign accept = !rst && (!o_vld || fifo_full_n);

  x_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

`ifdef XFIFO_ARB_PKT_LOCK_EN
  arb_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    gnt_oh   = pick_gnt;
    gnt_idx  = pick_idx;
    rr_ptr_d = rr_ptr;
    if (state_q == LOCK) begin
      // Owner keeps the grant even while idle so packets never interleave.
      gnt_oh           = '0;
      gnt_oh[grant_id] = 1'b1;
      gnt_idx          = grant_id;
    end
    req_ready = gnt_oh & req_valid & {N{accept}};
    fire      = |req_ready;
    case (state_q)
      ARB:     if (fire && !req_last[gnt_idx]) state_d = LOCK;
      LOCK:    if (fire && req_last[gnt_idx])  state_d = ARB;
      default: state_d = ARB;
    endcase
    if (fire && state_d == ARB) rr_ptr_d = next_id(gnt_idx);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  always_comb begin
    gnt_oh    = pick_gnt;
    gnt_idx   = pick_idx;
    req_ready = gnt_oh & req_valid & {N{accept}};
    fire      = |req_ready;
    rr_ptr_d  = fire ? next_id(gnt_idx) : rr_ptr;
  end
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh[i]) sel_data = req_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld    <= 1'b0;
      o_data   <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      rr_ptr <= rr_ptr_d;
      if (accept) o_vld <= fire;
      if (fire) begin
        o_data   <= {gnt_idx, sel_data};
        grant_id <= gnt_idx;
      end
    end
  end

  assign fifo_we  = o_vld;
  assign fifo_din = o_data;

endmodule

// File: tb/tb_x_fifo_wr_arb.sv
// Scoreboard bench for x_fifo_wr_arb: directed vectors push expected FIFO words, a negedge monitor pops and compares.
// Covers both XFIFO_ARB_PKT_LOCK_EN builds; ends with a long random phase checking per-source order and counts.
module tb_x_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int OW = DW + IW;
  localparam logic [3:0] T1_RDY [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_we;
  logic            fifo_full_n = 1'b1;
  logic [OW-1:0]   fifo_din;
  logic [IW-1:0]   grant_id;

  x_fifo_wr_arb #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_we     (fifo_we),
    .fifo_full_n (fifo_full_n),
    .fifo_din    (fifo_din),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  logic [7:0]    d [N];
  logic [OW-1:0] exp_q [$];
  logic [7:0]    src_q [N][$];
  logic [IW-1:0] mon_id;
  int  n_chk = 0, n_pass = 0, acc_cnt = 0, wr_cnt = 0;
  bit  random_mode = 1'b0;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_data(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
    d[0] = a; d[1] = b; d[2] = c; d[3] = e;
  endtask

  // One cycle: drive inputs, sample ready/we at negedge, advance the data of any accepted requester.
  task automatic tick(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                      output logic [3:0] rdy, output logic we);
    rst = r; req_valid = v; req_last = l; fifo_full_n = f;
    @(negedge clk);
    rdy = req_ready;
    we  = fifo_we;
    if (random_mode) begin
      for (int i = 0; i < N; i++) if (rdy[i]) begin
        src_q[i].push_back(d[i]);
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (rdy[i]) d[i] = d[i] + 8'd1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rdy_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (fifo_we && fifo_full_n) begin
        if (random_mode) begin
          wr_cnt++;
          mon_id = fifo_din[OW-1 -: IW];
          if (src_q[mon_id].size() == 0) begin
            n_chk++;
            $display("FAIL rand_write: got 0x%0h, expected no write from that source", fifo_din);
          end else begin
            chk("rand_order", 32'(fifo_din[DW-1:0]), 32'(src_q[mon_id].pop_front()));
          end
        end else if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL write: got 0x%0h, expected no write", fifo_din);
        end else begin
          chk("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       w;
    set_data(8'hA0, 8'hB0, 8'hC0, 8'hD0);

    // Reset with all requesters valid: nothing may be accepted.
    tick(1'b1, 4'hF, 4'hF, 1'b1, r, w);
    chk("rst_rdy", 32'(r), 32'd0);
    chk("rst_we", 32'(w), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);

    // Round robin across all four, single-beat packets.
    exp_q.push_back(10'h0A0); exp_q.push_back(10'h1B0); exp_q.push_back(10'h2C0);
    exp_q.push_back(10'h3D0); exp_q.push_back(10'h0A1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 4'hF, 4'hF, 1'b1, r, w);
      chk("rr_rdy", 32'(r), 32'(T1_RDY[i]));
      chk("rr_we", 32'(w), (i != 0) ? 32'd1 : 32'd0);
    end
    tick(1'b0, 4'h0, 4'hF, 1'b1, r, w);
    chk("rr_tail_we", 32'(w), 32'd1);
    tick(1'b0, 4'h0, 4'hF, 1'b1, r, w);
    chk("idle_we", 32'(w), 32'd0);
    chk("idle_gid", 32'(grant_id), 32'd0);

    // Backpressure: staged 0x15 from req1 must hold for 5 stalled cycles.
    set_data(8'hA0, 8'h15, 8'hC0, 8'hD0);
    exp_q.push_back(10'h115);
    tick(1'b0, 4'b0010, 4'hF, 1'b1, r, w);
    chk("bp_load_rdy", 32'(r), 32'b0010);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 4'hF, 4'hF, 1'b0, r, w);
      chk("bp_rdy", 32'(r), 32'd0);
      chk("bp_we", 32'(w), 32'd1);
      chk("bp_din", 32'(fifo_din), 32'h115);
    end
    chk("bp_gid", 32'(grant_id), 32'd1);
    exp_q.push_back(10'h2C0);
    tick(1'b0, 4'b0100, 4'hF, 1'b1, r, w);
    chk("bp_resume_rdy", 32'(r), 32'b0100);
    tick(1'b0, 4'h0, 4'hF, 1'b1, r, w);
    tick(1'b0, 4'h0, 4'hF, 1'b1, r, w);
    chk("bp_drained_we", 32'(w), 32'd0);

    tick(1'b1, 4'h0, 4'h0, 1'b1, r, w);
    chk("rst2_we", 32'(w), 32'd0);
    chk("rst2_gid", 32'(grant_id), 32'd0);
    set_data(8'hA0, 8'hB0, 8'hC0, 8'hD0);
`ifdef XFIFO_ARB_PKT_LOCK_EN
    // req0 3-beat packet with an idle cycle; req1 must wait for the last beat.
    exp_q.push_back(10'h0A0); exp_q.push_back(10'h0A1);
    exp_q.push_back(10'h0A2); exp_q.push_back(10'h1B0);
    tick(1'b0, 4'b0011, 4'b0000, 1'b1, r, w); chk("lock_b0", 32'(r), 32'b0001);
    tick(1'b0, 4'b0011, 4'b0000, 1'b1, r, w); chk("lock_b1", 32'(r), 32'b0001);
    tick(1'b0, 4'b0010, 4'b0000, 1'b1, r, w); chk("lock_idle", 32'(r), 32'b0000);
    tick(1'b0, 4'b0011, 4'b0001, 1'b1, r, w); chk("lock_b2", 32'(r), 32'b0001);
    tick(1'b0, 4'b0010, 4'b0010, 1'b1, r, w); chk("lock_rel", 32'(r), 32'b0010);
`else
    // req_last ignored: req0 and req1 alternate every beat.
    exp_q.push_back(10'h0A0); exp_q.push_back(10'h1B0);
    exp_q.push_back(10'h0A1); exp_q.push_back(10'h1B1);
    tick(1'b0, 4'b0011, 4'b0000, 1'b1, r, w); chk("alt_0", 32'(r), 32'b0001);
    tick(1'b0, 4'b0011, 4'b0000, 1'b1, r, w); chk("alt_1", 32'(r), 32'b0010);
    tick(1'b0, 4'b0011, 4'b0000, 1'b1, r, w); chk("alt_2", 32'(r), 32'b0001);
    tick(1'b0, 4'b0011, 4'b0000, 1'b1, r, w); chk("alt_3", 32'(r), 32'b0010);
`endif
    tick(1'b0, 4'h0, 4'h0, 1'b1, r, w);
    tick(1'b0, 4'h0, 4'h0, 1'b1, r, w);

    // Reset after first beat of a packet: staged beat dropped, req1 wins right after release.
    set_data(8'hA0, 8'hB0, 8'hC0, 8'hD0);
    tick(1'b0, 4'b0011, 4'b0000, 1'b1, r, w);
    chk("mid_first_rdy", 32'(r), 32'b0001);
    tick(1'b1, 4'b0000, 4'b0000, 1'b1, r, w);
    chk("mid_rst_we", 32'(w), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    exp_q.push_back(10'h1B0);
    tick(1'b0, 4'b0010, 4'b0010, 1'b1, r, w);
    chk("mid_req1_rdy", 32'(r), 32'b0010);
    tick(1'b0, 4'h0, 4'h0, 1'b1, r, w);
    tick(1'b0, 4'h0, 4'h0, 1'b1, r, w);
    chk("directed_drain", 32'(exp_q.size()), 32'd0);

    // Random traffic and backpressure.
    random_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      tick(1'b0, 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), r, w);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h0, 4'h0, 1'b1, r, w);
    for (int i = 0; i < N; i++) chk("rand_src_drain", 32'(src_q[i].size()), 32'd0);
    chk("rand_count", 32'(wr_cnt), 32'(acc_cnt));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
